// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared types and constants for the HI/LO multiply/divide controller
package hilo_pkg;

  localparam int MD_ITERS = 32;
  localparam int CNT_W    = $clog2(MD_ITERS);

  typedef enum logic [1:0] {
    OP_MULTU = 2'd0,
    OP_MULT  = 2'd1,
    OP_DIVU  = 2'd2,
    OP_DIV   = 2'd3
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/hilo_md_ctrl_if.sv
// rtl/hilo_md_ctrl_if.sv - EX-stage request bus and HI/LO result bus of the multiply/divide controller
interface hilo_md_ctrl_if;

  logic        md_start_E;
  logic [1:0]  md_op_E;
  logic [31:0] md_a_E;
  logic [31:0] md_b_E;
  logic        mt_we_E;
  logic        mt_sel_E;
  logic [31:0] mt_data_E;
  logic        mf_req_E;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall_md;
  logic        md_done;

  modport master (
    output md_start_E, md_op_E, md_a_E, md_b_E, mt_we_E, mt_sel_E, mt_data_E, mf_req_E,
    input  hi, lo, busy, stall_md, md_done
  );

  modport slave (
    input  md_start_E, md_op_E, md_a_E, md_b_E, mt_we_E, mt_sel_E, mt_data_E, mf_req_E,
    output hi, lo, busy, stall_md, md_done
  );

endinterface

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - one shift-add multiply or restoring divide step per enable on unsigned magnitudes
// HILO_DIV_EN adds the restoring divider and its quotient/remainder outputs.
module md_iter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        en,
  input  logic        is_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] product
`ifdef HILO_DIV_EN
  ,
  output logic [31:0] quotient,
  output logic [31:0] remainder
`endif
);

  // acc is the 64-bit product for multiply, {remainder, quotient} for divide.
  logic [63:0] acc;
  logic [31:0] opb;
  logic [32:0] add_sum;

  assign add_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);

`ifdef HILO_DIV_EN
  logic [32:0] shifted;
  logic [32:0] trial;

  assign shifted = {acc[63:32], acc[31]};
  assign trial   = shifted - {1'b0, opb};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 64'd0;
      opb <= 32'd0;
    end else if (load) begin
      acc <= {32'd0, a};
      opb <= b;
    end else if (en) begin
`ifdef HILO_DIV_EN
      if (is_div) begin
        if (!trial[32]) acc <= {trial[31:0], acc[30:0], 1'b1};
        else            acc <= {shifted[31:0], acc[30:0], 1'b0};
      end else begin
        acc <= {add_sum, acc[31:1]};
      end
`else
      if (!is_div) acc <= {add_sum, acc[31:1]};
`endif
    end
  end

  assign product = acc;
`ifdef HILO_DIV_EN
  assign quotient  = acc[31:0];
  assign remainder = acc[63:32];
`endif

endmodule

// File: rtl/hilo_md_ctrl.sv
// rtl/hilo_md_ctrl.sv - HI/LO owner: multiply/divide FSM, sign fix-up, MTHI/MTLO writes and front-end stall
// HILO_DIV_EN enables DIVU/DIV; without it divide issues are ignored.
module hilo_md_ctrl
  import hilo_pkg::*;
(
  input logic           clk,
  input logic           rst,
  hilo_md_ctrl_if.slave bus
);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt;
  md_op_t           op;
  logic             signed_op, accept, last_step, busy_w;
  logic             is_div_r, neg_res_r, md_done_r;
  logic [31:0]      a_mag, b_mag, hi_r, lo_r;
  logic [63:0]      product, prod_fix;
`ifdef HILO_DIV_EN
  logic             neg_rem_r, div_zero_r;
  logic [31:0]      quotient, remainder;
`endif

  assign op        = md_op_t'(bus.md_op_E);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign a_mag     = signed_op ? mag32(bus.md_a_E) : bus.md_a_E;
  assign b_mag     = signed_op ? mag32(bus.md_b_E) : bus.md_b_E;
`ifdef HILO_DIV_EN
  assign accept    = (state == ST_IDLE) && bus.md_start_E;
`else
  assign accept    = (state == ST_IDLE) && bus.md_start_E && !op[1];
`endif
  assign last_step = (cnt == CNT_W'(MD_ITERS - 1));
  assign busy_w    = (state != ST_IDLE);
  assign prod_fix  = neg_res_r ? (~product + 64'd1) : product;

  md_iter_core u_core (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .en        (state == ST_RUN),
    .is_div    (is_div_r),
    .a         (a_mag),
    .b         (b_mag),
    .product   (product)
`ifdef HILO_DIV_EN
    ,
    .quotient  (quotient),
    .remainder (remainder)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_FIX;
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      is_div_r   <= 1'b0;
      neg_res_r  <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
      md_done_r  <= 1'b0;
`ifdef HILO_DIV_EN
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
`endif
    end else begin
      md_done_r <= 1'b0;
      if (accept) begin
        cnt        <= '0;
        is_div_r   <= op[1];
        neg_res_r  <= signed_op & (bus.md_a_E[31] ^ bus.md_b_E[31]);
`ifdef HILO_DIV_EN
        neg_rem_r  <= signed_op & bus.md_a_E[31];
        div_zero_r <= (bus.md_b_E == 32'd0);
`endif
      end else if (state == ST_RUN) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == ST_FIX) begin
        md_done_r <= 1'b1;
`ifdef HILO_DIV_EN
        // Divide by zero keeps the old HI/LO but still retires on schedule.
        if (is_div_r) begin
          if (!div_zero_r) begin
            hi_r <= neg_rem_r ? (~remainder + 32'd1) : remainder;
            lo_r <= neg_res_r ? (~quotient + 32'd1) : quotient;
          end
        end else
`endif
        {hi_r, lo_r} <= prod_fix;
      end else if (state == ST_IDLE && bus.mt_we_E && !bus.md_start_E) begin
        if (bus.mt_sel_E) hi_r <= bus.mt_data_E;
        else              lo_r <= bus.mt_data_E;
      end
    end
  end

  assign bus.hi       = hi_r;
  assign bus.lo       = lo_r;
  assign bus.busy     = busy_w;
  assign bus.md_done  = md_done_r;
  assign bus.stall_md = busy_w && (bus.md_start_E || bus.mt_we_E || bus.mf_req_E);

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// tb/tb_hilo_md_ctrl.sv - scoreboard bench for hilo_md_ctrl (divide cases follow HILO_DIV_EN)
module tb_hilo_md_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_md_ctrl_if bus ();
  hilo_md_ctrl dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] sh_hi = 32'd0;
  logic [31:0] sh_lo = 32'd0;

  always @(posedge clk) begin
    if (bus.md_start_E === 1'b1 && bus.mt_we_E === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL illegal_start_with_mt start=%b mt_we=%b required=not both", bus.md_start_E, bus.mt_we_E);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.md_start_E = 1'b0; bus.md_op_E = 2'd0; bus.md_a_E = 32'd0; bus.md_b_E = 32'd0;
    bus.mt_we_E = 1'b0; bus.mt_sel_E = 1'b0; bus.mt_data_E = 32'd0; bus.mf_req_E = 1'b0;
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int     qa, qb;
    case (op)
      2'd0: return {32'd0, a} * {32'd0, b};
      2'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
      end
      2'd2: if (b == 32'd0) return {sh_hi, sh_lo}; else return {a % b, a / b};
      default: begin
        if (b == 32'd0) return {sh_hi, sh_lo};
        qa = $signed(a);
        qb = $signed(b);
        return {32'(qa % qb), 32'(qa / qb)};
      end
    endcase
  endfunction

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_q.push_back(model(op, a, b));
    bus.md_start_E = 1'b1; bus.md_op_E = op; bus.md_a_E = a; bus.md_b_E = b;
    tick();
    bus.md_start_E = 1'b0;
  endtask

  // Called right after the accepting edge; returns once md_done is seen or the budget runs out.
  task automatic wait_done(input string name, output int lat, output int nbusy);
    logic [63:0] exp;
    bit          seen = 1'b0;
    lat = 0; nbusy = 0;
    while (!seen && lat < 40) begin
      if (bus.busy) nbusy++;
      tick();
      lat++;
      if (bus.md_done) seen = 1'b1;
    end
    checks++;
    exp = exp_q.pop_front();
    if (!seen) begin
      failures++;
      $display("FAIL %s_timeout md_done not seen within %0d cycles required=33", name, lat);
    end else if ({bus.hi, bus.lo} !== exp) begin
      failures++;
      $display("FAIL %s_result hilo=%h required=%h", name, {bus.hi, bus.lo}, exp);
    end
    {sh_hi, sh_lo} = exp;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int lat, nbusy;
    start_op(op, a, b);
    wait_done(name, lat, nbusy);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL %s_latency got=%0d required=33", name, lat); end
    checks++;
    if (nbusy !== 33) begin failures++; $display("FAIL %s_busy_cycles got=%0d required=33", name, nbusy); end
    tick();
    checks++;
    if (bus.md_done !== 1'b0) begin failures++; $display("FAIL %s_done_once md_done=%b required=0", name, bus.md_done); end
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] data);
    bus.mt_we_E = 1'b1; bus.mt_sel_E = sel; bus.mt_data_E = data;
    tick();
    bus.mt_we_E = 1'b0;
    if (sel) sh_hi = data; else sh_lo = data;
    checks++;
    if ({bus.hi, bus.lo} !== {sh_hi, sh_lo}) begin
      failures++;
      $display("FAIL mt_write sel=%b hilo=%h required=%h", sel, {bus.hi, bus.lo}, {sh_hi, sh_lo});
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (2) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.hi, bus.lo, bus.busy, bus.stall_md, bus.md_done} !== 67'd0) begin
      failures++;
      $display("FAIL reset_state hi=%h lo=%h busy=%b stall=%b done=%b required=all zero",
               bus.hi, bus.lo, bus.busy, bus.stall_md, bus.md_done);
    end
  endtask

  task automatic test_mt_idle();
    mt_write(1'b0, 32'h0000CAFE);
    checks++;
    if (bus.lo !== 32'h0000CAFE) begin failures++; $display("FAIL mtlo_idle lo=%h required=0000cafe", bus.lo); end
  endtask

  task automatic test_mult();
    run_op(2'd0, 32'hFFFFFFFF, 32'h00000002, "multu_max_x2");
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000001_FFFFFFFE) begin
      failures++; $display("FAIL multu_const hilo=%h required=00000001fffffffe", {bus.hi, bus.lo});
    end
    run_op(2'd1, 32'hFFFFFFFD, 32'd5, "mult_neg3_x5");
    checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFF1) begin
      failures++; $display("FAIL mult_const hilo=%h required=fffffffffffffff1", {bus.hi, bus.lo});
    end
    run_op(2'd1, 32'h80000000, 32'h80000000, "mult_minint_sq");
    for (int i = 0; i < 4; i++) begin
      run_op(2'(i % 2), $urandom, $urandom, "mult_random");
    end
  endtask

`ifdef HILO_DIV_EN
  task automatic test_div();
    run_op(2'd3, 32'hFFFFFFF9, 32'd2, "div_neg7_by2");
    checks++;
    if ({bus.hi, bus.lo} !== 64'hFFFFFFFF_FFFFFFFD) begin
      failures++; $display("FAIL div_const hilo=%h required=fffffffffffffffd", {bus.hi, bus.lo});
    end
    mt_write(1'b1, 32'h00001234);
    mt_write(1'b0, 32'h00005555);
    run_op(2'd2, 32'd7, 32'd0, "divu_by_zero");
    checks++;
    if (bus.hi !== 32'h00001234) begin failures++; $display("FAIL divu_zero_hi hi=%h required=00001234", bus.hi); end
    for (int i = 0; i < 3; i++) begin
      logic [31:0] b;
      b = $urandom_range(2, 1000);
      if ($urandom_range(0, 1) == 1) b = -b;
      run_op(2'd3, $urandom, b, "div_random");
      run_op(2'd2, $urandom, $urandom_range(1, 32'h7FFFFFFF), "divu_random");
    end
  endtask
`else
  task automatic test_div_disabled();
    int ndone = 0;
    bus.md_start_E = 1'b1; bus.md_op_E = 2'd3; bus.md_a_E = 32'hFFFFFFF9; bus.md_b_E = 32'd2;
    #1;
    checks++;
    if (bus.stall_md !== 1'b0) begin failures++; $display("FAIL div_off_stall stall=%b required=0", bus.stall_md); end
    tick();
    bus.md_start_E = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL div_off_busy busy=%b required=0", bus.busy); end
    repeat (40) begin
      if (bus.md_done) ndone++;
      tick();
    end
    checks++;
    if (ndone !== 0 || {bus.hi, bus.lo} !== {sh_hi, sh_lo}) begin
      failures++;
      $display("FAIL div_off_ignored done_pulses=%0d hilo=%h required=0 and %h", ndone, {bus.hi, bus.lo}, {sh_hi, sh_lo});
    end
  endtask
`endif

  task automatic test_mf_stall();
    int          n = 0;
    logic [63:0] exp;
    exp = model(2'd0, 32'h00012345, 32'h00067890);
    start_op(2'd0, 32'h00012345, 32'h00067890);
    tick();
    bus.mf_req_E = 1'b1;
    #1;
    while (bus.stall_md && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 32) begin failures++; $display("FAIL mf_stall_cycles got=%0d required=32", n); end
    checks++;
    if (bus.md_done !== 1'b1 || bus.hi !== exp[63:32]) begin
      failures++;
      $display("FAIL mf_read_hi done=%b hi=%h required=1 and %h", bus.md_done, bus.hi, exp[63:32]);
    end
    void'(exp_q.pop_front());
    {sh_hi, sh_lo} = exp;
    bus.mf_req_E = 1'b0;
    tick();
  endtask

  task automatic test_mt_busy();
    int n = 0;
    int lat, nbusy;
    start_op(2'd0, 32'd3, 32'd4);
    bus.mt_we_E = 1'b1; bus.mt_sel_E = 1'b0; bus.mt_data_E = 32'h0000BEEF;
    #1;
    while (bus.stall_md && n < 40) begin
      n++;
      tick();
    end
    checks++;
    if (n !== 33) begin failures++; $display("FAIL mt_busy_stall_cycles got=%0d required=33", n); end
    checks++;
    if (bus.md_done !== 1'b1 || {bus.hi, bus.lo} !== exp_q[0]) begin
      failures++;
      $display("FAIL mt_busy_mult done=%b hilo=%h required=1 and %h", bus.md_done, {bus.hi, bus.lo}, exp_q[0]);
    end
    void'(exp_q.pop_front());
    tick();
    bus.mt_we_E = 1'b0;
    sh_hi = 32'd0; sh_lo = 32'h0000BEEF;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h00000000_0000BEEF) begin
      failures++; $display("FAIL mt_busy_override hilo=%h required=000000000000beef", {bus.hi, bus.lo});
    end
    lat = 0; nbusy = 0;
  endtask

  task automatic test_back_to_back();
    int lat, nbusy;
    start_op(2'd1, 32'hFFFFFF00, 32'h00000100);
    wait_done("b2b_first", lat, nbusy);
    exp_q.push_back(model(2'd0, 32'hDEADBEEF, 32'h00000010));
    bus.md_start_E = 1'b1; bus.md_op_E = 2'd0; bus.md_a_E = 32'hDEADBEEF; bus.md_b_E = 32'h00000010;
    #1;
    checks++;
    if (bus.stall_md !== 1'b0) begin failures++; $display("FAIL b2b_no_stall stall=%b required=0", bus.stall_md); end
    tick();
    bus.md_start_E = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.md_done !== 1'b0) begin
      failures++; $display("FAIL b2b_accept busy=%b done=%b required=1 and 0", bus.busy, bus.md_done);
    end
    wait_done("b2b_second", lat, nbusy);
    checks++;
    if (lat !== 33) begin failures++; $display("FAIL b2b_latency got=%0d required=33", lat); end
    tick();
  endtask

  task automatic test_rst_mid();
    int ndone = 0;
    bus.md_start_E = 1'b1; bus.md_op_E = 2'd0; bus.md_a_E = 32'h12345678; bus.md_b_E = 32'h9ABCDEF0;
    tick();
    bus.md_start_E = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sh_hi = 32'd0; sh_lo = 32'd0;
    checks++;
    if ({bus.busy, bus.md_done, bus.hi, bus.lo} !== 66'd0) begin
      failures++;
      $display("FAIL rst_mid_state busy=%b done=%b hi=%h lo=%h required=all zero", bus.busy, bus.md_done, bus.hi, bus.lo);
    end
    repeat (40) begin
      if (bus.md_done) ndone++;
      tick();
    end
    checks++;
    if (ndone !== 0) begin failures++; $display("FAIL rst_mid_no_done pulses=%0d required=0", ndone); end
    run_op(2'd0, 32'd6, 32'd7, "multu_after_rst");
    checks++;
    if (bus.lo !== 32'd42) begin failures++; $display("FAIL multu_6x7 lo=%0d required=42", bus.lo); end
  endtask

  initial begin
    test_reset();
    test_mt_idle();
    test_mult();
`ifdef HILO_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_mf_stall();
    test_mt_busy();
    test_back_to_back();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
